// File: rtl/score_overlay.sv
// Score tracker and on-screen score overlay for the VGA colour mux.
// Latency: score/high-score update 1 cycle after the triggering edge; render is combinational.
// Backpressure: none; the pixel stream and game events are consumed every cycle.
//
// Optional feature macro: HIGH_SCORE_EN (adds the high-score register and a second strip).
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   apple_collected   level, one score increment per rising edge while in PLAY
//   game_state        00 IDLE, 01 PLAY, 11 GAME_OVER
//   x_pos, y_pos      current pixel position
//   score_active, rgb overlay hit and colour for the current pixel
//   score_bcd         registered score, most significant digit in the top nibble
//   high_bcd          registered high score (tied 0 without HIGH_SCORE_EN)
module score_overlay #(
  parameter int BIT     = 10,
  parameter int DIGITS  = 3,
  parameter int X_START = 16,
  parameter int Y_START = 4,
  parameter int HS_X    = 560
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  apple_collected,
  input  logic [1:0]            game_state,
  input  logic [BIT-1:0]        x_pos,
  input  logic [BIT-1:0]        y_pos,
  output logic                  score_active,
  output logic [2:0]            rgb,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd
);

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_OVER = 2'b11
  } game_state_e;

  localparam logic [4*DIGITS-1:0] SCORE_MAX = {DIGITS{4'h9}};

`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic                prev_apple;
  logic [1:0]          prev_state;
  logic                inc;
  logic                clr;
  logic [4*DIGITS-1:0] score_inc;

  assign inc = apple_collected & ~prev_apple & (game_state == GS_PLAY);
  assign clr = (prev_state == GS_IDLE) & (game_state == GS_PLAY);

  // BCD +1 with ripple carry from the least significant nibble upward.
  always_comb begin
    logic carry;
    score_inc = score_bcd;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_apple <= 1'b0;
      prev_state <= GS_IDLE;
      score_bcd  <= '0;
    end else begin
      prev_apple <= apple_collected;
      prev_state <= game_state;
      if (clr) begin
        score_bcd <= '0;
      end else if (inc && (score_bcd != SCORE_MAX)) begin
        score_bcd <= score_inc;
      end
    end
  end

`ifdef HIGH_SCORE_EN
  // Valid BCD orders the same as plain unsigned, so a packed compare is numeric.
  // No increment can coincide with PLAY->GAME_OVER, so score_bcd is final here.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_bcd <= '0;
    end else if ((prev_state == GS_PLAY) && (game_state == GS_OVER) &&
                 (score_bcd > high_bcd)) begin
      high_bcd <= score_bcd;
    end
  end
`else
  assign high_bcd = '0;
`endif

  // 3x5 font, rows top to bottom in bits [14:12] .. [2:0], MSB of each row is the left column.
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = 15'b000_000_000_000_000;
    endcase
  endfunction

  // True when (x, y) falls on a lit font pixel of a DIGITS-wide strip whose
  // leftmost cell starts at base_x. Cells are 12x20 on a 16 px pitch, 4x4 px per font pixel.
  function automatic logic strip_lit(input logic [BIT-1:0] x, input logic [BIT-1:0] y,
                                     input int base_x, input logic [4*DIGITS-1:0] bcd);
    int          dx;
    int          dy;
    logic [3:0]  d;
    logic [3:0]  bit_idx;
    logic [14:0] g;
    logic        lit;
    lit = 1'b0;
    dy  = int'(y) - Y_START;
    for (int i = 0; i < DIGITS; i++) begin
      dx = int'(x) - base_x - 16*i;
      if (dx >= 0 && dx < 12 && dy >= 0 && dy < 20) begin
        d       = 4'(bcd >> (4*(DIGITS-1-i)));
        g       = glyph(d);
        bit_idx = 4'(14 - 3*(dy/4) - dx/4);
        lit     = g[bit_idx];
      end
    end
    return lit;
  endfunction

  // Score strip is evaluated last so it wins over the high-score strip.
  always_comb begin
    score_active = 1'b0;
    rgb          = 3'b000;
    if (HS_EN && strip_lit(x_pos, y_pos, HS_X, high_bcd)) begin
      score_active = 1'b1;
      rgb          = 3'b110;
    end
    if (strip_lit(x_pos, y_pos, X_START, score_bcd)) begin
      score_active = 1'b1;
      rgb          = 3'b111;
    end
  end

endmodule
